// File: rtl/fetch_packet_packer_if.sv
// ---------------------------------------------------------------------------
// fetch_packet_packer_if
//   Bundles the fetch-side and buffer-side handshakes of fetch_packet_packer.
//   Signal names keep the packer's point of view (_i into the packer, _o out).
//
//   in_valid_i  / in_ready_o  : fetch packet handshake
//   in_mask_i   [IN_WIDTH]    : sparse slot-valid mask
//   in_data_i   [IN_WIDTH]    : slot data, DATA_WIDTH bits each
//   out_valid_o / out_ready_i : dense burst handshake towards the buffer
//   out_num_o   [CNT_W]       : number of valid lanes in the burst
//   out_data_o  [OUT_WIDTH]   : lanes 0..out_num_o-1 valid, others zero
//
//   modport slave  : the packer itself
//   modport master : whoever drives packets in and consumes bursts (bench)
// ---------------------------------------------------------------------------
interface fetch_packet_packer_if #(
  parameter int IN_WIDTH   = 8,
  parameter int OUT_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int CNT_W = $clog2(OUT_WIDTH + 1);

  logic                                  in_valid_i;
  logic                                  in_ready_o;
  logic [IN_WIDTH-1:0]                   in_mask_i;
  logic [IN_WIDTH-1:0][DATA_WIDTH-1:0]   in_data_i;
  logic                                  out_valid_o;
  logic                                  out_ready_i;
  logic [CNT_W-1:0]                      out_num_o;
  logic [OUT_WIDTH-1:0][DATA_WIDTH-1:0]  out_data_o;

  modport slave (
    input  in_valid_i, in_mask_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_num_o, out_data_o
  );

  modport master (
    output in_valid_i, in_mask_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_num_o, out_data_o
  );
endinterface

// File: rtl/fetch_packet_packer.sv
// ---------------------------------------------------------------------------
// fetch_packet_packer
//   Compacts fetch packets with an arbitrary slot-valid mask into dense write
//   bursts for the instruction buffer: valid slots are packed from lane 0 in
//   ascending slot order with a lane count. Packets with more valid slots
//   than OUT_WIDTH drain over several bursts. One cycle from accept to burst.
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   flush_i      synchronous flush: drops the held and the incoming packet
//   bus          fetch_packet_packer_if.slave (packet in, burst out)
//   stall_cnt_o  (only with PACKER_STALL_CNT_EN) saturating count of cycles
//                with a burst presented but not taken; cleared by rst_n only
//
// Configuration macro: PACKER_STALL_CNT_EN
// ---------------------------------------------------------------------------
module fetch_packet_packer #(
  parameter int IN_WIDTH   = 8,
  parameter int OUT_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
`ifdef PACKER_STALL_CNT_EN
  output logic [31:0]           stall_cnt_o,
`endif
  fetch_packet_packer_if.slave  bus
);
  localparam int CNT_W  = $clog2(OUT_WIDTH + 1);
  // Ranks run up to IN_WIDTH, so they need more bits than the lane count.
  localparam int RANK_W = $clog2(IN_WIDTH + 1);

  logic [IN_WIDTH-1:0]                 hold_mask_reg;
  logic [IN_WIDTH-1:0][DATA_WIDTH-1:0] hold_data_reg;

  logic [RANK_W-1:0]   rank [IN_WIDTH];  // number of held slots below slot i
  logic [RANK_W-1:0]   pop_cnt;
  logic [IN_WIDTH-1:0] sel_mask;         // slots carried by the current burst
  logic                hold_empty;
  logic                last_burst;
  logic                fire;
  logic                accept;
  logic                in_ready;

  // Prefix popcount: the rank of a held slot is its output lane.
  always_comb begin : rank_calc
    logic [RANK_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      rank[i] = acc;
      acc     = acc + RANK_W'(hold_mask_reg[i]);
    end
    pop_cnt = acc;
  end

  genvar gi;
  generate
    for (gi = 0; gi < IN_WIDTH; gi++) begin : g_sel
      assign sel_mask[gi] = hold_mask_reg[gi] & (rank[gi] < RANK_W'(OUT_WIDTH));
    end

    // Each lane picks the unique held slot whose rank equals the lane index.
    for (gi = 0; gi < OUT_WIDTH; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] lane_val;
      always_comb begin
        lane_val = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
          if (hold_mask_reg[i] && (rank[i] == RANK_W'(gi))) begin
            lane_val = lane_val | hold_data_reg[i];
          end
        end
      end
      assign bus.out_data_o[gi] = lane_val;
    end
  endgenerate

  assign hold_empty = ~|hold_mask_reg;
  assign last_burst = (pop_cnt <= RANK_W'(OUT_WIDTH));

  // Burst side depends on registers only.
  assign bus.out_valid_o = ~hold_empty;
  assign bus.out_num_o   = last_burst ? CNT_W'(pop_cnt) : CNT_W'(OUT_WIDTH);

  assign fire = ~hold_empty & bus.out_ready_i;

  // out_ready_i -> in_ready_o is combinational on purpose: a packet can be
  // taken in the same cycle its predecessor's final burst leaves.
  assign in_ready       = rst_n & ~flush_i & (hold_empty | (fire & last_burst));
  assign bus.in_ready_o = in_ready;
  assign accept         = bus.in_valid_i & in_ready;

  // Flush beats accept (in_ready is already low) and beats the clear; accept
  // overrides the clear because the old packet has fully drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_mask_reg <= '0;
    end else if (flush_i) begin
      hold_mask_reg <= '0;
    end else if (accept) begin
      hold_mask_reg <= bus.in_mask_i;
    end else if (fire) begin
      hold_mask_reg <= hold_mask_reg & ~sel_mask;
    end
  end

  // Data is only observed through the mask, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data_reg <= bus.in_data_i;
    end
  end

`ifdef PACKER_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (~hold_empty && !bus.out_ready_i && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_packet_packer.sv
// ---------------------------------------------------------------------------
// tb_fetch_packet_packer
//   Directed vector table for the packer (one row per cycle, continuing
//   scenarios), followed by a randomised run checked against a slot queue.
// ---------------------------------------------------------------------------
module tb_fetch_packet_packer;
  localparam int IW = 8;
  localparam int OW = 4;
  localparam int DW = 32;

  logic clk;
  logic rst_n;
  logic flush;
`ifdef PACKER_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int tests_run;
  int tests_failed;

  fetch_packet_packer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DATA_WIDTH(DW)) bus ();

  fetch_packet_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
`ifdef PACKER_STALL_CNT_EN
    .stall_cnt_o (stall_cnt),
`endif
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [7:0]   mask;
    logic [31:0]  base;
    logic         ordy;
    logic         fl;
    logic         e_ov;
    logic [2:0]   e_num;
    logic         e_ir;
    logic [127:0] e_data;
    int           e_stall;   // -1: not checked
  } vec_t;

  vec_t vecs[$];

  function automatic logic [127:0] l4(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  function automatic void add(input logic v, input logic [7:0] mask, input logic [31:0] base,
                              input logic ordy, input logic fl, input logic e_ov,
                              input logic [2:0] e_num, input logic e_ir,
                              input logic [127:0] e_data, input int e_stall);
    vec_t r;
    r.v = v; r.mask = mask; r.base = base; r.ordy = ordy; r.fl = fl;
    r.e_ov = e_ov; r.e_num = e_num; r.e_ir = e_ir; r.e_data = e_data; r.e_stall = e_stall;
    vecs.push_back(r);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] mask, input logic [31:0] base,
                       input logic ordy, input logic fl);
    bus.in_valid_i  = v;
    bus.in_mask_i   = mask;
    bus.out_ready_i = ordy;
    flush           = fl;
    for (int i = 0; i < IW; i++) bus.in_data_i[i] = base + 32'(i);
  endtask

  logic [31:0] sb_q[$];
  logic [31:0] rnd_data [IW];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);

    // Rows: v, mask, base, out_ready, flush | out_valid, num, in_ready, lanes, stall
    // 1: sparse packet, single burst
    add(1, 8'hA5, 32'h00, 1, 0,  0, 0, 1, l4(0, 0, 0, 0), -1);
    add(0, 8'h00, 32'h00, 1, 0,  1, 4, 1, l4(32'h00, 32'h02, 32'h05, 32'h07), -1);
    add(0, 8'h00, 32'h00, 1, 0,  0, 0, 1, l4(0, 0, 0, 0), -1);
    // 2: full packet, two bursts, next packet taken on the last burst
    add(1, 8'hFF, 32'h10, 1, 0,  0, 0, 1, l4(0, 0, 0, 0), -1);
    add(1, 8'h0F, 32'h20, 1, 0,  1, 4, 0, l4(32'h10, 32'h11, 32'h12, 32'h13), -1);
    add(1, 8'h0F, 32'h20, 1, 0,  1, 4, 1, l4(32'h14, 32'h15, 32'h16, 32'h17), -1);
    add(0, 8'h00, 32'h00, 1, 0,  1, 4, 1, l4(32'h20, 32'h21, 32'h22, 32'h23), -1);
    add(0, 8'h00, 32'h00, 1, 0,  0, 0, 1, l4(0, 0, 0, 0), -1);
    // 3: three stall cycles then drain
    add(1, 8'hFF, 32'h30, 1, 0,  0, 0, 1, l4(0, 0, 0, 0), -1);
    add(0, 8'h00, 32'h00, 0, 0,  1, 4, 0, l4(32'h30, 32'h31, 32'h32, 32'h33), -1);
    add(0, 8'h00, 32'h00, 0, 0,  1, 4, 0, l4(32'h30, 32'h31, 32'h32, 32'h33), -1);
    add(0, 8'h00, 32'h00, 0, 0,  1, 4, 0, l4(32'h30, 32'h31, 32'h32, 32'h33), -1);
    add(0, 8'h00, 32'h00, 1, 0,  1, 4, 0, l4(32'h30, 32'h31, 32'h32, 32'h33), 3);
    add(0, 8'h00, 32'h00, 1, 0,  1, 4, 1, l4(32'h34, 32'h35, 32'h36, 32'h37), -1);
    add(0, 8'h00, 32'h00, 1, 0,  0, 0, 1, l4(0, 0, 0, 0), -1);
    // 4: empty mask accepted and dropped
    add(1, 8'h00, 32'h40, 1, 0,  0, 0, 1, l4(0, 0, 0, 0), -1);
    add(0, 8'h00, 32'h00, 1, 0,  0, 0, 1, l4(0, 0, 0, 0), -1);
    // 5: flush on the second burst's fire cycle, then a single-slot packet
    add(1, 8'hFF, 32'h50, 1, 0,  0, 0, 1, l4(0, 0, 0, 0), -1);
    add(0, 8'h00, 32'h00, 1, 0,  1, 4, 0, l4(32'h50, 32'h51, 32'h52, 32'h53), -1);
    add(1, 8'hFF, 32'h60, 1, 1,  1, 4, 0, l4(32'h54, 32'h55, 32'h56, 32'h57), -1);
    add(1, 8'h01, 32'h70, 1, 0,  0, 0, 1, l4(0, 0, 0, 0), -1);
    add(0, 8'h00, 32'h00, 1, 0,  1, 1, 1, l4(32'h70, 0, 0, 0), -1);
    add(0, 8'h00, 32'h00, 1, 0,  0, 0, 1, l4(0, 0, 0, 0), -1);
    // Sparse 5-slot packet: 4 + 1 drain, stalled tail, back-to-back accept
    add(1, 8'hDA, 32'h80, 1, 0,  0, 0, 1, l4(0, 0, 0, 0), -1);
    add(0, 8'h00, 32'h00, 1, 0,  1, 4, 0, l4(32'h81, 32'h83, 32'h84, 32'h86), -1);
    add(1, 8'h80, 32'h90, 0, 0,  1, 1, 0, l4(32'h87, 0, 0, 0), -1);
    add(1, 8'h80, 32'h90, 1, 0,  1, 1, 1, l4(32'h87, 0, 0, 0), -1);
    add(0, 8'h00, 32'h00, 1, 0,  1, 1, 1, l4(32'h97, 0, 0, 0), 4);
    add(0, 8'h00, 32'h00, 1, 0,  0, 0, 1, l4(0, 0, 0, 0), -1);

    // Reset state
    repeat (3) tick();
    check("reset_in_ready",  128'(bus.in_ready_o),  128'(0));
    check("reset_out_valid", 128'(bus.out_valid_o), 128'(0));
    check("reset_out_num",   128'(bus.out_num_o),   128'(0));
    check("reset_out_data",  128'(bus.out_data_o),  128'(0));
    rst_n = 1'b1;

    for (int r = 0; r < vecs.size(); r++) begin
      drive(vecs[r].v, vecs[r].mask, vecs[r].base, vecs[r].ordy, vecs[r].fl);
      #1;
      check($sformatf("vec%0d_out_valid", r), 128'(bus.out_valid_o), 128'(vecs[r].e_ov));
      check($sformatf("vec%0d_out_num", r),   128'(bus.out_num_o),   128'(vecs[r].e_num));
      check($sformatf("vec%0d_in_ready", r),  128'(bus.in_ready_o),  128'(vecs[r].e_ir));
      check($sformatf("vec%0d_out_data", r),  128'(bus.out_data_o),  vecs[r].e_data);
`ifdef PACKER_STALL_CNT_EN
      if (vecs[r].e_stall >= 0)
        check($sformatf("vec%0d_stall_cnt", r), 128'(stall_cnt), 128'(vecs[r].e_stall));
`endif
      tick();
    end

    // Random traffic checked against an in-order slot queue
    sb_q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic       v, ordy, fl, eir;
      logic [7:0] mask;
      int         qs, en;
      v    = ($urandom_range(0, 9) < 6);
      mask = 8'($urandom);
      if ($urandom_range(0, 3) == 0) mask = mask & 8'($urandom);
      ordy = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 15) == 0);
      bus.in_valid_i  = v;
      bus.in_mask_i   = mask;
      bus.out_ready_i = ordy;
      flush           = fl;
      for (int i = 0; i < IW; i++) begin
        rnd_data[i]      = $urandom;
        bus.in_data_i[i] = rnd_data[i];
      end
      #1;
      qs  = sb_q.size();
      en  = (qs > OW) ? OW : qs;
      eir = !fl && ((qs == 0) || (ordy && (qs <= OW)));
      check($sformatf("rnd%0d_out_valid", c), 128'(bus.out_valid_o), 128'(qs != 0));
      check($sformatf("rnd%0d_out_num", c),   128'(bus.out_num_o),   128'(en));
      check($sformatf("rnd%0d_in_ready", c),  128'(bus.in_ready_o),  128'(eir));
      for (int k = 0; k < OW; k++) begin
        logic [31:0] exp_lane;
        exp_lane = (k < en) ? sb_q[k] : 32'h0;
        check($sformatf("rnd%0d_lane%0d", c, k), 128'(bus.out_data_o[k]), 128'(exp_lane));
      end
      if ((qs != 0) && ordy) begin
        for (int k = 0; k < en; k++) void'(sb_q.pop_front());
      end
      if (fl) begin
        sb_q.delete();
      end else if (v && eir) begin
        for (int i = 0; i < IW; i++) if (mask[i]) sb_q.push_back(rnd_data[i]);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
